fir_sample_sequencer: RTL

//   Schedules ADC sampling and steps the 22-tap symmetric FIR datapath (3 register stages) through a clock enable.
//   - Sample rate: a programmable divider.
//   - ADC access: a req/ack handshake.
//   - Startup: flushes the filter with zeros, then counts warm-up samples and qualifies filtered results.
//   - Position: sits between the ADC interface and the binary-search controller, which consumes filt_data/filt_valid.

---
 rtl/fir_sample_sequencer.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/fir_sample_sequencer.sv
// Sample scheduler for the symmetric FIR: divides the filter clock into sample ticks,
// runs the ADC req/ack handshake, flushes the FIR at startup and qualifies its output.
module fir_sample_sequencer #(
  parameter int DIV    = 50,
  parameter int WARMUP = 25,
  parameter int DW     = 8,
  parameter int OW     = 20
) (
  input  logic          CLK_Filter,
  input  logic          rst_n,
  input  logic          start,
  input  logic          stop,
  output logic          adc_req,
  input  logic          adc_ack,
  input  logic [DW-1:0] adc_data,
  output logic          fir_ce,
  output logic [DW-1:0] fir_din,
  input  logic [OW-1:0] fir_dout,
  output logic [OW-1:0] filt_data,
  output logic          filt_valid,
  output logic          busy,
  output logic          primed,
  output logic          overrun
);

  localparam int DCW = $clog2(DIV);
  localparam int CW  = $clog2(WARMUP + 1);
  localparam logic [DCW-1:0] DIV_LAST   = DCW'(DIV - 1);
  localparam logic [CW-1:0]  WARM_FULL  = CW'(WARMUP);
  localparam logic [CW-1:0]  FLUSH_LAST = CW'(WARMUP - 1);

  typedef enum logic [2:0] {
    IDLE,
    FLUSH,
    WAIT_TICK,
    REQ,
    PUSH,
    CAPTURE
  } state_t;

  state_t         state_q, state_d;
  logic [DCW-1:0] div_cnt_q, div_cnt_d;
  logic [CW-1:0]  push_cnt_q, push_cnt_d;
  logic [CW-1:0]  flush_cnt_q, flush_cnt_d;
  logic [DW-1:0]  sample_q, sample_d;
  logic [DW-1:0]  fir_din_q;
  logic [OW-1:0]  filt_data_q, filt_data_d;
  logic           filt_valid_q, filt_valid_d;
  logic           overrun_q, overrun_d;
  logic           stop_pend_q, stop_pend_d;
  logic           running;
  logic           tick;

  // The divider keeps running through the handshake so the sample grid stays fixed.
  assign running = (state_q == WAIT_TICK) || (state_q == REQ) ||
                   (state_q == PUSH) || (state_q == CAPTURE);
  assign tick    = running && (div_cnt_q == DIV_LAST);

  assign busy       = (state_q != IDLE);
  assign primed     = (push_cnt_q == WARM_FULL);
  assign overrun    = overrun_q;
  assign filt_data  = filt_data_q;
  assign filt_valid = filt_valid_q;

  always_comb begin
    state_d      = state_q;
    div_cnt_d    = '0;
    push_cnt_d   = push_cnt_q;
    flush_cnt_d  = flush_cnt_q;
    sample_d     = sample_q;
    filt_data_d  = filt_data_q;
    filt_valid_d = 1'b0;
    overrun_d    = overrun_q;
    stop_pend_d  = stop_pend_q;
    fir_ce       = 1'b0;
    fir_din      = fir_din_q;
    adc_req      = 1'b0;

    if (running) begin
      div_cnt_d = tick ? '0 : div_cnt_q + 1'b1;
    end
    // A tick that lands while a sample is still in flight is dropped and flagged.
    if (tick && (state_q != WAIT_TICK)) begin
      overrun_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        stop_pend_d = 1'b0;
        if (start && !stop) begin
          state_d     = FLUSH;
          push_cnt_d  = '0;
          flush_cnt_d = '0;
          overrun_d   = 1'b0;
        end
      end
      FLUSH: begin
        fir_ce  = 1'b1;
        fir_din = '0;
        if (flush_cnt_q != WARM_FULL) begin
          flush_cnt_d = flush_cnt_q + 1'b1;
        end
        if (flush_cnt_q == FLUSH_LAST) begin
          state_d = WAIT_TICK;
        end
      end
      WAIT_TICK: begin
        if (stop) begin
          state_d   = IDLE;
          div_cnt_d = '0;
        end else if (tick) begin
          state_d = REQ;
        end
      end
      REQ: begin
        adc_req     = 1'b1;
        stop_pend_d = stop_pend_q | stop;
        if (adc_ack) begin
          sample_d = adc_data;
          state_d  = PUSH;
        end
      end
      PUSH: begin
        fir_ce      = 1'b1;
        fir_din     = sample_q;
        stop_pend_d = stop_pend_q | stop;
        if (push_cnt_q != WARM_FULL) begin
          push_cnt_d = push_cnt_q + 1'b1;
        end
        state_d = CAPTURE;
      end
      CAPTURE: begin
        filt_data_d  = fir_dout;
        filt_valid_d = primed;
        if (stop_pend_q || stop) begin
          state_d     = IDLE;
          stop_pend_d = 1'b0;
          div_cnt_d   = '0;
        end else begin
          state_d = WAIT_TICK;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK_Filter or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      div_cnt_q    <= '0;
      push_cnt_q   <= '0;
      flush_cnt_q  <= '0;
      sample_q     <= '0;
      fir_din_q    <= '0;
      filt_data_q  <= '0;
      filt_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
      stop_pend_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      div_cnt_q    <= div_cnt_d;
      push_cnt_q   <= push_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
      sample_q     <= sample_d;
      fir_din_q    <= fir_din;
      filt_data_q  <= filt_data_d;
      filt_valid_q <= filt_valid_d;
      overrun_q    <= overrun_d;
      stop_pend_q  <= stop_pend_d;
    end
  end

endmodule
